scope_cmd_parser: RTL and testbench
===================================

// Module: scope_cmd_parser
// PURPOSE
//  Framed, multi-channel successor to the single-byte host command decoder.
//  Takes bytes from the UART receiver and assembles 4-byte frames: HDR, OP, ARG, CHK.
//  Validates each frame and updates per-channel acquisition/trigger registers.
//  Timeouts and checksum failures are reported; only whole, valid frames change state.
// PARAMETERS
//  NUM_CH      2        number of analog channels (2..16)
//  LEVEL_W     8        trigger level width (<=8, carried in ARG)
//  LEVEL_MAX   8'hAB    highest legal trigger level (+5V); 8'h00 = -5V
//  LEVEL_DEF   8'h55    reset/default trigger level (~0V)
//  HDR_BYTE    8'hA5    frame header byte
//  TIMEOUT_CYC 50000    max clk cycles between bytes inside a frame
// PORTS
//  clk           in   1                system clock
//  rst           in   1                synchronous reset, active-high
//  rx_data       in   8                received byte
//  rx_valid      in   1                1-cycle strobe: rx_data is valid
//  gather_set    out  2                00 stop/reset, 01 continuous, 10 single
//  single_arm    out  1                1-cycle pulse when single mode is (re)commanded
//  trig_src      out  $clog2(NUM_CH)   trigger source channel
//  trig_edge     out  NUM_CH           per channel: 0 rising, 1 falling
//  trig_level    out  NUM_CH*LEVEL_W   per-channel level; ch n at [n*LEVEL_W +: LEVEL_W]
//  ch_enable     out  NUM_CH           per-channel display/capture enable
//  cmd_ack       out  1                1-cycle pulse: frame executed
//  cmd_err       out  1                1-cycle pulse: frame rejected
//  err_code      out  2                01 checksum, 10 bad opcode/arg, 11 timeout; holds until next err
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//   - gather_set=00, single_arm=0, trig_src=0, trig_edge=0, trig_level[all]=LEVEL_DEF.
//   - ch_enable=all 1, cmd_ack=0, cmd_err=0, err_code=00, FSM=IDLE, timer=0.
//   - rst overrides a frame in progress; that frame is discarded silently.
//  Frame format:
//   - OP[7:4] = channel c, OP[3:0] = function f.
//   - CHK = OP ^ ARG.
//  FSM (advances only on rx_valid):
//   - IDLE: waits for HDR_BYTE; other bytes are ignored, no error.
//   - GET_OP: latches OP.
//   - GET_ARG: latches ARG.
//   - GET_CHK: compares the byte with OP^ARG, then goes to EXEC.
//   - EXEC: lasts 1 cycle, returns to IDLE; rx_valid arriving during EXEC is ignored.
//   - Byte received in GET_OP equal to HDR_BYTE is treated as OP (no resync).
//  Timeout:
//   - Timer clears on every accepted byte; counts only in GET_OP/GET_ARG/GET_CHK.
//   - Timer reaching TIMEOUT_CYC -> cmd_err pulse, err_code=11, FSM=IDLE.
//   - If rx_valid and timeout fall on the same cycle, the byte wins (timer clears).
//  EXEC:
//   - Checksum fail -> err 01.
//   - c >= NUM_CH (f=1..5) or illegal f/ARG -> err 10.
//   - Otherwise the function executes and cmd_ack pulses.
//  Functions:
//   - f=0 global reset: all outputs to reset values; ARG and c ignored.
//   - f=1 gather mode: ARG 00/01/02 -> gather_set; ARG=02 also pulses single_arm.
//     Pulse happens even if already 10 (re-arm). ARG>02 -> err 10.
//   - f=2 edge: trig_edge[c] = ARG[0]; ARG[7:1] must be 0, else err 10.
//   - f=3 level: ARG > LEVEL_MAX -> err 10, level unchanged; else trig_level[c] = ARG[LEVEL_W-1:0].
//   - f=4 trigger source: trig_src = c; ARG ignored.
//   - f=5 channel enable: ch_enable[c] = ARG[0].
//   - f=6..15: err 10.
//  Timing:
//   - Latency: register updates, cmd_ack/cmd_err and single_arm are all visible
//     on the cycle after the posedge that accepted CHK (EXEC cycle registered).
//   - cmd_ack and cmd_err are never high together.
//   - Rejected frames change no register except err_code.
// TESTING
//  - rst; frame A5 01 02 03 (ch0 gather single) -> gather_set=10, single_arm 1 cycle, cmd_ack 1 cycle.
//  - A5 13 80 93 (ch1 level 80) -> trig_level[15:8]=80, ch0 level stays 55.
//    Then A5 13 AC BF -> cmd_err, err_code=10, level stays 80.
//  - A5 02 01 04 (bad CHK, expect 03) -> cmd_err, err_code=01, trig_edge unchanged.
//    Then A5 02 01 03 -> trig_edge[0]=1.
//  - Send A5 12, idle TIMEOUT_CYC cycles -> cmd_err, err_code=11, FSM IDLE.
//    Then a full valid frame is accepted.
//  - Stray bytes 00 F1 33 in IDLE -> no ack/err; then A5 14 00 14 -> trig_src=1.
//  - rst asserted after A5 01 -> no ack; following 01 02 03 ignored (no HDR), outputs at reset values.

Source files
------------

// File: rtl/scope_cmd_parser.sv
// Framed host command parser: assembles HDR/OP/ARG/CHK frames from UART bytes,
// validates them and updates per-channel acquisition and trigger registers.
module scope_cmd_parser #(
  parameter int          NUM_CH      = 2,
  parameter int          LEVEL_W     = 8,
  parameter logic [7:0]  LEVEL_MAX   = 8'hAB,
  parameter logic [7:0]  LEVEL_DEF   = 8'h55,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CYC = 50000,
  localparam int         SRC_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int         TMR_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [1:0]                gather_set,
  output logic                      single_arm,
  output logic [SRC_W-1:0]          trig_src,
  output logic [NUM_CH-1:0]         trig_edge,
  output logic [NUM_CH*LEVEL_W-1:0] trig_level,
  output logic [NUM_CH-1:0]         ch_enable,
  output logic                      cmd_ack,
  output logic                      cmd_err,
  output logic [1:0]                err_code,
  output logic [2:0]                dbg_state
);

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte is
  // consumed on the posedge where rx_valid=1, except in EXEC where it is dropped.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_OP  = 3'd1,
    S_GET_ARG = 3'd2,
    S_GET_CHK = 3'd3,
    S_EXEC    = 3'd4
  } state_t;

  localparam logic [4:0]       NUM_CH_L = 5'(NUM_CH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [7:0]       r_op;
  logic [7:0]       r_arg;

  logic [3:0]       w_ch;
  logic [3:0]       w_fn;
  logic             w_ch_ok;
  logic             w_chk_ok;
  logic             w_bad;

  assign dbg_state = r_state;

  always_comb begin
    w_ch     = r_op[7:4];
    w_fn     = r_op[3:0];
    w_ch_ok  = ({1'b0, w_ch} < NUM_CH_L);
    w_chk_ok = (rx_data == (r_op ^ r_arg));
    w_bad    = 1'b1;
    case (w_fn)
      4'd0:       w_bad = 1'b0;
      4'd1:       w_bad = !w_ch_ok || (r_arg > 8'd2);
      4'd2:       w_bad = !w_ch_ok || (r_arg[7:1] != 7'd0);
      4'd3:       w_bad = !w_ch_ok || (r_arg > LEVEL_MAX);
      4'd4, 4'd5: w_bad = !w_ch_ok;
      default:    w_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_op       <= '0;
      r_arg      <= '0;
      gather_set <= 2'b00;
      single_arm <= 1'b0;
      trig_src   <= '0;
      trig_edge  <= '0;
      trig_level <= {NUM_CH{LEVEL_DEF[LEVEL_W-1:0]}};
      ch_enable  <= '1;
      cmd_ack    <= 1'b0;
      cmd_err    <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      cmd_ack    <= 1'b0;
      cmd_err    <= 1'b0;
      single_arm <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (rx_valid && (rx_data == HDR_BYTE)) r_state <= S_GET_OP;
        end
        S_GET_OP, S_GET_ARG, S_GET_CHK: begin
          // An arriving byte beats a simultaneous timeout.
          if (rx_valid) begin
            r_timer <= '0;
            if (r_state == S_GET_OP) begin
              r_op    <= rx_data;
              r_state <= S_GET_ARG;
            end else if (r_state == S_GET_ARG) begin
              r_arg   <= rx_data;
              r_state <= S_GET_CHK;
            end else begin
              r_state <= S_EXEC;
              if (!w_chk_ok) begin
                cmd_err  <= 1'b1;
                err_code <= 2'b01;
              end else if (w_bad) begin
                cmd_err  <= 1'b1;
                err_code <= 2'b10;
              end else begin
                cmd_ack <= 1'b1;
                case (w_fn)
                  4'd0: begin
                    gather_set <= 2'b00;
                    trig_src   <= '0;
                    trig_edge  <= '0;
                    trig_level <= {NUM_CH{LEVEL_DEF[LEVEL_W-1:0]}};
                    ch_enable  <= '1;
                    err_code   <= 2'b00;
                  end
                  4'd1: begin
                    gather_set <= r_arg[1:0];
                    single_arm <= (r_arg[1:0] == 2'b10);
                  end
                  4'd2: begin
                    for (int n = 0; n < NUM_CH; n++)
                      if (w_ch == 4'(n)) trig_edge[n] <= r_arg[0];
                  end
                  4'd3: begin
                    for (int n = 0; n < NUM_CH; n++)
                      if (w_ch == 4'(n)) trig_level[n*LEVEL_W +: LEVEL_W] <= r_arg[LEVEL_W-1:0];
                  end
                  4'd4: trig_src <= SRC_W'(w_ch);
                  4'd5: begin
                    for (int n = 0; n < NUM_CH; n++)
                      if (w_ch == 4'(n)) ch_enable[n] <= r_arg[0];
                  end
                  default: ;
                endcase
              end
            end
          end else if (r_timer == TMR_LAST) begin
            cmd_err  <= 1'b1;
            err_code <= 2'b11;
            r_state  <= S_IDLE;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_EXEC:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scope_cmd_parser.sv
// Bench for scope_cmd_parser: directed frames plus random frames checked
// against a frame-level behavioural model of the command set.
module tb_scope_cmd_parser;

  localparam int         NUM_CH    = 2;
  localparam int         LEVEL_W   = 8;
  localparam logic [7:0] LEVEL_MAX = 8'hAB;
  localparam logic [7:0] LEVEL_DEF = 8'h55;
  localparam logic [7:0] HDR       = 8'hA5;
  localparam int         TMO       = 200;
  localparam int         SRC_W     = 1;

  logic                      clk;
  logic                      rst;
  logic [7:0]                rx_data;
  logic                      rx_valid;
  logic [1:0]                gather_set;
  logic                      single_arm;
  logic [SRC_W-1:0]          trig_src;
  logic [NUM_CH-1:0]         trig_edge;
  logic [NUM_CH*LEVEL_W-1:0] trig_level;
  logic [NUM_CH-1:0]         ch_enable;
  logic                      cmd_ack;
  logic                      cmd_err;
  logic [1:0]                err_code;
  logic [2:0]                dbg_state;

  scope_cmd_parser #(
    .NUM_CH(NUM_CH), .LEVEL_W(LEVEL_W), .LEVEL_MAX(LEVEL_MAX),
    .LEVEL_DEF(LEVEL_DEF), .HDR_BYTE(HDR), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .gather_set(gather_set), .single_arm(single_arm), .trig_src(trig_src),
    .trig_edge(trig_edge), .trig_level(trig_level), .ch_enable(ch_enable),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err), .err_code(err_code),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  int n_ack_seen = 0;
  int n_err_seen = 0;
  int n_ack_exp = 0;
  int n_err_exp = 0;
  logic [2:0] exp_q[$];

  // reference model
  logic [1:0] m_gather;
  int         m_src;
  logic       m_edge[NUM_CH];
  int         m_level[NUM_CH];
  logic       m_en[NUM_CH];
  logic [1:0] m_err_code;

  always @(negedge clk) begin
    if (cmd_ack) n_ack_seen++;
    if (cmd_err) n_err_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_gather = 2'b00;
    m_src = 0;
    m_err_code = 2'b00;
    for (int n = 0; n < NUM_CH; n++) begin
      m_edge[n]  = 1'b0;
      m_level[n] = int'(LEVEL_DEF);
      m_en[n]    = 1'b1;
    end
  endtask

  // Returns {ack, err, arm} for one complete frame and updates the model.
  task automatic model_frame(input logic [7:0] op, input logic [7:0] arg,
                             input logic [7:0] chk, output logic [2:0] resp);
    int  c;
    int  f;
    bit  legal;
    c = int'(op[7:4]);
    f = int'(op[3:0]);
    resp = 3'b000;
    if (chk != (op ^ arg)) begin
      m_err_code = 2'b01;
      resp = 3'b010;
      return;
    end
    if (f == 0)                 legal = 1;
    else if (f > 5)             legal = 0;
    else if (c >= NUM_CH)       legal = 0;
    else if (f == 1)            legal = (arg <= 2);
    else if (f == 2)            legal = (arg <= 1);
    else if (f == 3)            legal = (arg <= LEVEL_MAX);
    else                        legal = 1;
    if (!legal) begin
      m_err_code = 2'b10;
      resp = 3'b010;
      return;
    end
    resp = 3'b100;
    case (f)
      0: model_reset();
      1: begin
        m_gather = arg[1:0];
        if (arg == 2) resp[0] = 1'b1;
      end
      2: m_edge[c]  = arg[0];
      3: m_level[c] = int'(arg);
      4: m_src      = c;
      5: m_en[c]    = arg[0];
      default: ;
    endcase
  endtask

  task automatic compare_state(input string tag);
    logic [NUM_CH*LEVEL_W-1:0] lv;
    logic [NUM_CH-1:0]         ed;
    logic [NUM_CH-1:0]         en;
    for (int n = 0; n < NUM_CH; n++) begin
      lv[n*LEVEL_W +: LEVEL_W] = m_level[n][LEVEL_W-1:0];
      ed[n] = m_edge[n];
      en[n] = m_en[n];
    end
    check_eq({tag, ".gather"}, 32'(gather_set), 32'(m_gather));
    check_eq({tag, ".src"},    32'(trig_src),   32'(m_src));
    check_eq({tag, ".edge"},   32'(trig_edge),  32'(ed));
    check_eq({tag, ".level"},  32'(trig_level), 32'(lv));
    check_eq({tag, ".enable"}, 32'(ch_enable),  32'(en));
    check_eq({tag, ".errcode"}, 32'(err_code),  32'(m_err_code));
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_frame(input string tag, input logic [7:0] op,
                            input logic [7:0] arg, input logic [7:0] chk);
    logic [2:0] resp;
    logic [2:0] exp;
    send_byte(HDR);
    send_byte(op);
    send_byte(arg);
    model_frame(op, arg, chk, resp);
    exp_q.push_back(resp);
    if (resp[2]) n_ack_exp++;
    if (resp[1]) n_err_exp++;
    @(negedge clk);
    rx_data  = chk;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    exp = exp_q.pop_front();
    check_eq({tag, ".ack"}, 32'(cmd_ack),    32'(exp[2]));
    check_eq({tag, ".err"}, 32'(cmd_err),    32'(exp[1]));
    check_eq({tag, ".arm"}, 32'(single_arm), 32'(exp[0]));
    compare_state(tag);
    @(negedge clk);
    check_eq({tag, ".pulse_end"}, 32'({cmd_ack, cmd_err, single_arm}), 32'd0);
    check_eq({tag, ".idle"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int cnt;
    logic [7:0] op;
    logic [7:0] arg;
    logic [7:0] chk;
    logic [7:0] b;
    int a0;
    int a1;

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    compare_state("reset");
    check_eq("reset.pulses", 32'({cmd_ack, cmd_err, single_arm}), 32'd0);
    check_eq("reset.state", 32'(dbg_state), 32'd0);

    send_frame("gather_single", 8'h01, 8'h02, 8'h03);
    send_frame("rearm", 8'h01, 8'h02, 8'h03);
    send_frame("level80", 8'h13, 8'h80, 8'h93);
    send_frame("level_over", 8'h13, 8'hAC, 8'hBF);
    send_frame("level_max", 8'h03, 8'hAB, 8'hA8);
    send_frame("bad_chk", 8'h02, 8'h01, 8'h04);
    send_frame("edge_fall", 8'h02, 8'h01, 8'h03);
    send_frame("edge_badarg", 8'h12, 8'h03, 8'h11);
    send_frame("bad_ch", 8'h24, 8'h00, 8'h24);
    send_frame("bad_fn", 8'h06, 8'h00, 8'h06);

    // timeout mid-frame
    send_byte(HDR);
    send_byte(8'h12);
    cnt = 0;
    while (!cmd_err && cnt < 2 * TMO) begin
      @(negedge clk);
      cnt++;
    end
    m_err_code = 2'b11;
    n_err_exp++;
    check_eq("timeout.cycles", 32'(cnt), 32'(TMO));
    check_eq("timeout.ack", 32'(cmd_ack), 32'd0);
    compare_state("timeout");
    @(negedge clk);
    check_eq("timeout.idle", 32'(dbg_state), 32'd0);
    send_frame("after_timeout", 8'h15, 8'h00, 8'h15);

    // stray bytes in IDLE
    a0 = n_ack_seen;
    a1 = n_err_seen;
    send_byte(8'h00);
    send_byte(8'hF1);
    send_byte(8'h33);
    check_eq("stray.ack", 32'(n_ack_seen - a0), 32'd0);
    check_eq("stray.err", 32'(n_err_seen - a1), 32'd0);
    send_frame("src1", 8'h14, 8'h00, 8'h14);

    // reset in the middle of a frame
    send_byte(HDR);
    send_byte(8'h01);
    do_reset();
    a0 = n_ack_seen;
    a1 = n_err_seen;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (2) @(negedge clk);
    check_eq("rst_mid.ack", 32'(n_ack_seen - a0), 32'd0);
    check_eq("rst_mid.err", 32'(n_err_seen - a1), 32'd0);
    compare_state("rst_mid");

    // randomized frames
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == HDR) b = 8'h00;
        send_byte(b);
      end
      op = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 7))};
      case ($urandom_range(0, 5))
        0: arg = 8'h00;
        1: arg = 8'h01;
        2: arg = 8'h02;
        3: arg = 8'h03;
        4: arg = 8'($urandom_range(0, 255));
        default: arg = LEVEL_MAX + 8'($urandom_range(0, 1));
      endcase
      chk = op ^ arg;
      if ($urandom_range(0, 7) == 0) chk = chk ^ (8'd1 << $urandom_range(0, 7));
      send_frame("rand", op, arg, chk);
    end

    repeat (2) @(negedge clk);
    check_eq("total.ack", 32'(n_ack_seen), 32'(n_ack_exp));
    check_eq("total.err", 32'(n_err_seen), 32'(n_err_exp));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
